ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, range 1-15: consecutive data grants allowed while fetch waits (used only under REQ-027).
REQ-002 SHALL have port clk_i, in, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n_i, in, 1: reset, synchronous, active-low.
REQ-004 SHALL have port if_req_i, in, 1: fetch request; if_addr_i, in, 64: fetch PC.
REQ-005 SHALL have port if_gnt_o, out, 1: fetch grant pulse; if_rvalid_o, out, 1: instruction valid pulse; if_instr_o, out, 80: instruction bytes; if_err_o, out, 1: fetch memory error.
REQ-006 SHALL have port dm_req_i, in, 1; dm_we_i, in, 1 (1=write); dm_addr_i, in, 64; dm_wdata_i, in, 64: data-memory request.
REQ-007 SHALL have port dm_gnt_o, out, 1; dm_done_o, out, 1: read or write complete pulse; dm_rdata_o, out, 64; dm_err_o, out, 1.
REQ-008 SHALL have port ram_read_en_o, ram_write_en_o, ram_read_instruction_o, out, 1 each; ram_addr_o, out, 64; ram_write_data_o, out, 64: RAM command.
REQ-009 SHALL have port ram_read_data_i, in, 64; ram_read_instruction_i, in, 80; ram_dmem_error_i, in, 1: RAM response, valid the cycle after a command cycle.
REQ-010 SHALL have port busy_o, out, 1: high whenever state is not IDLE.

Function
REQ-011 SHALL implement an FSM with states IDLE, ISSUE, WAIT; ISSUE->WAIT and WAIT->IDLE are unconditional.
REQ-012 IDLE with no request SHALL stay IDLE with all RAM enables low.
REQ-013 IDLE with a request at cycle t SHALL select a winner, register its command, and enter ISSUE at t+1.
REQ-014 In ISSUE (t+1), the winner's gnt_o SHALL be high for exactly that cycle, with ram_addr_o and enables driven from the registered command.
REQ-015 A fetch command SHALL drive ram_read_en_o=1, ram_read_instruction_o=1, ram_write_en_o=0.
REQ-016 A data read SHALL drive ram_read_en_o=1, others 0; a data write SHALL drive ram_write_en_o=1 with ram_write_data_o=dm_wdata_i captured at t.
REQ-017 In WAIT (t+2), all RAM enables SHALL be 0; RAM response and ram_dmem_error_i SHALL be captured at the end of WAIT.
REQ-018 At t+3 (IDLE), the winner's rvalid/done SHALL pulse for one cycle with captured data; err_o SHALL equal captured ram_dmem_error_i for that cycle, 0 otherwise.
REQ-019 if_instr_o and dm_rdata_o SHALL hold their last captured value until the next completion of their own port; a write SHALL leave dm_rdata_o unchanged.
REQ-020 Arbitration in the t+3 IDLE cycle SHALL be allowed; sustained throughput SHALL be one access per 3 cycles.
REQ-021 If both requests are high in IDLE, data SHALL win (default priority).
REQ-022 Requesters SHALL hold req and fields until gnt; a req dropped before grant SHALL cause no access.
REQ-023 Fields changed after the sampling edge t SHALL NOT affect the in-flight access.
REQ-024 Requests arriving in ISSUE or WAIT SHALL be ignored until IDLE; no request queueing.

Reset
REQ-025 rst_n_i low at a rising edge SHALL force IDLE and set every output, command register, captured data and starvation counter to 0, regardless of state.
REQ-026 Reset during ISSUE or WAIT SHALL abort the access; no rvalid/done pulse for it after reset release.

Configuration
REQ-027 With macro RAM_ARB_STARVE_GUARD_EN defined: counter increments on each data grant while if_req_i is high, clears on any fetch grant; when it equals STARVE_LIMIT, fetch SHALL win the next simultaneous arbitration.
REQ-028 Without RAM_ARB_STARVE_GUARD_EN: no counter; strict data priority per REQ-021.

Verification
REQ-029 Reset, then if_req_i=1, if_addr_i=0x10, RAM instr=0x..30F2 -> if_gnt_o at t+1, ram_read_instruction_o=1 at t+1, if_rvalid_o at t+3, if_instr_o=RAM value.
REQ-030 dm_req_i=1, dm_we_i=1, addr=0x100, wdata=0xDEADBEEF -> ram_write_en_o=1 with those values at t+1 only, dm_done_o at t+3, dm_rdata_o unchanged.
REQ-031 if_req_i and dm_req_i both held high -> dm_gnt_o first; if_gnt_o 3 cycles later after data req drops; busy_o high exactly in ISSUE/WAIT.
REQ-032 Macro defined, STARVE_LIMIT=2, both reqs always high -> grant order D,D,F,D,D,F; macro undefined -> D forever.
REQ-033 rst_n_i low during WAIT of a data read -> all outputs 0 next cycle, no dm_done_o pulse; data read with ram_dmem_error_i=1 in WAIT -> dm_err_o=1 with dm_done_o.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-ported RAM: one access per 3 cycles.
// Optional fetch starvation guard enabled by defining RAM_ARB_STARVE_GUARD_EN.
module ram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        if_req_i,
    input  logic [63:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [79:0] if_instr_o,
    output logic        if_err_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [63:0] dm_addr_i,
    input  logic [63:0] dm_wdata_i,
    output logic        dm_gnt_o,
    output logic        dm_done_o,
    output logic [63:0] dm_rdata_o,
    output logic        dm_err_o,
    output logic        ram_read_en_o,
    output logic        ram_write_en_o,
    output logic        ram_read_instruction_o,
    output logic [63:0] ram_addr_o,
    output logic [63:0] ram_write_data_o,
    input  logic [63:0] ram_read_data_i,
    input  logic [79:0] ram_read_instruction_i,
    input  logic        ram_dmem_error_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_cmd_fetch;
    logic        r_cmd_we;
    logic [63:0] r_cmd_addr;
    logic [63:0] r_cmd_wdata;
    logic [79:0] r_instr;
    logic [63:0] r_rdata;
    logic        r_if_rvalid;
    logic        r_if_err;
    logic        r_dm_done;
    logic        r_dm_err;
    logic        w_any_req;
    logic        w_pick_fetch;

    assign w_any_req = if_req_i | dm_req_i;

`ifdef RAM_ARB_STARVE_GUARD_EN
    logic [3:0] r_starve_cnt;
    logic       w_starved;

    assign w_starved    = (r_starve_cnt == 4'(STARVE_LIMIT));
    assign w_pick_fetch = if_req_i & (~dm_req_i | w_starved);

    // Counts data wins that left a pending fetch waiting; any fetch win resets it.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_starve_cnt <= 4'd0;
        end else if (r_state == IDLE && w_any_req) begin
            if (w_pick_fetch)
                r_starve_cnt <= 4'd0;
            else if (if_req_i)
                r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`else
    assign w_pick_fetch = if_req_i & ~dm_req_i;
`endif

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n_i)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_next           = r_state;
        if_gnt_o               = 1'b0;
        dm_gnt_o               = 1'b0;
        ram_read_en_o          = 1'b0;
        ram_write_en_o         = 1'b0;
        ram_read_instruction_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req)
                    w_state_next = ISSUE;
            end
            ISSUE: begin
                w_state_next           = WAIT;
                if_gnt_o               = r_cmd_fetch;
                dm_gnt_o               = ~r_cmd_fetch;
                ram_read_en_o          = r_cmd_fetch | ~r_cmd_we;
                ram_write_en_o         = ~r_cmd_fetch & r_cmd_we;
                ram_read_instruction_o = r_cmd_fetch;
            end
            WAIT: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Command capture at the arbitration edge; response capture at the end of WAIT.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_cmd_fetch <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= 64'd0;
            r_cmd_wdata <= 64'd0;
            r_instr     <= 80'd0;
            r_rdata     <= 64'd0;
            r_if_rvalid <= 1'b0;
            r_if_err    <= 1'b0;
            r_dm_done   <= 1'b0;
            r_dm_err    <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_if_err    <= 1'b0;
            r_dm_done   <= 1'b0;
            r_dm_err    <= 1'b0;
            if (r_state == IDLE && w_any_req) begin
                r_cmd_fetch <= w_pick_fetch;
                r_cmd_we    <= ~w_pick_fetch & dm_we_i;
                r_cmd_addr  <= w_pick_fetch ? if_addr_i : dm_addr_i;
                r_cmd_wdata <= w_pick_fetch ? 64'd0 : dm_wdata_i;
            end
            if (r_state == WAIT) begin
                if (r_cmd_fetch) begin
                    r_if_rvalid <= 1'b1;
                    r_if_err    <= ram_dmem_error_i;
                    r_instr     <= ram_read_instruction_i;
                end else begin
                    r_dm_done <= 1'b1;
                    r_dm_err  <= ram_dmem_error_i;
                    if (!r_cmd_we)
                        r_rdata <= ram_read_data_i;
                end
            end
        end
    end

    assign if_rvalid_o      = r_if_rvalid;
    assign if_err_o         = r_if_err;
    assign if_instr_o       = r_instr;
    assign dm_done_o        = r_dm_done;
    assign dm_err_o         = r_dm_err;
    assign dm_rdata_o       = r_rdata;
    assign ram_addr_o       = r_cmd_addr;
    assign ram_write_data_o = r_cmd_wdata;
    assign busy_o           = (r_state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table of single accesses, a scoreboard of
// expected completions, and hand sequences for priority, throughput, starvation and reset abort.
module tb_ram_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        if_req_i;
    logic [63:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o, if_err_o;
    logic [79:0] if_instr_o;
    logic        dm_req_i, dm_we_i;
    logic [63:0] dm_addr_i, dm_wdata_i;
    logic        dm_gnt_o, dm_done_o, dm_err_o;
    logic [63:0] dm_rdata_o;
    logic        ram_read_en_o, ram_write_en_o, ram_read_instruction_o;
    logic [63:0] ram_addr_o, ram_write_data_o;
    logic [63:0] ram_read_data_i;
    logic [79:0] ram_read_instruction_i;
    logic        ram_dmem_error_i;
    logic        busy_o;

    localparam logic [63:0] ERR_ADDR = 64'hBAD0;

    always #5 clk_i = ~clk_i;

    ram_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_instr_o(if_instr_o), .if_err_o(if_err_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_gnt_o(dm_gnt_o), .dm_done_o(dm_done_o), .dm_rdata_o(dm_rdata_o), .dm_err_o(dm_err_o),
        .ram_read_en_o(ram_read_en_o), .ram_write_en_o(ram_write_en_o),
        .ram_read_instruction_o(ram_read_instruction_o),
        .ram_addr_o(ram_addr_o), .ram_write_data_o(ram_write_data_o),
        .ram_read_data_i(ram_read_data_i), .ram_read_instruction_i(ram_read_instruction_i),
        .ram_dmem_error_i(ram_dmem_error_i), .busy_o(busy_o)
    );

    function automatic logic [79:0] mem_instr(input logic [63:0] a);
        return {a, 16'h30F2};
    endfunction

    function automatic logic [63:0] mem_data(input logic [63:0] a);
        return a ^ 64'hA5A5_0000_5A5A_FFFF;
    endfunction

    // RAM model: response is valid only in the cycle after a command cycle.
    logic        resp_valid;
    logic [63:0] resp_addr;
    always @(posedge clk_i) begin
        resp_valid <= ram_read_en_o | ram_write_en_o;
        resp_addr  <= ram_addr_o;
    end
    assign ram_read_data_i        = resp_valid ? mem_data(resp_addr) : 64'd0;
    assign ram_read_instruction_i = resp_valid ? mem_instr(resp_addr) : 80'd0;
    assign ram_dmem_error_i       = resp_valid && (resp_addr == ERR_ADDR);

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        fetch;
        logic [79:0] data;
        logic        err;
        int          gnt_cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [63:0] exp_rdata = 64'd0;

    task automatic push_exp(input logic fetch, input logic we, input logic [63:0] addr);
        exp_t e;
        e.fetch   = fetch;
        e.err     = (addr == ERR_ADDR);
        e.gnt_cyc = cyc;
        if (fetch) begin
            e.data = mem_instr(addr);
        end else begin
            if (!we) exp_rdata = mem_data(addr);
            e.data = {16'd0, exp_rdata};
        end
        sb.push_back(e);
    endtask

    // Completion monitor: pops the scoreboard on every rvalid/done pulse.
    always @(negedge clk_i) begin
        if (if_rvalid_o || dm_done_o) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {if_rvalid_o, dm_done_o}, 2'b00);
            end else begin
                mon_e = sb.pop_front();
                check("done_port", {if_rvalid_o, dm_done_o}, {mon_e.fetch, ~mon_e.fetch});
                check("done_latency", 80'(cyc - mon_e.gnt_cyc), 80'd2);
                if (mon_e.fetch) begin
                    check("if_instr", if_instr_o, mon_e.data);
                    check("if_err", if_err_o, mon_e.err);
                end else begin
                    check("dm_rdata", dm_rdata_o, mon_e.data);
                    check("dm_err", dm_err_o, mon_e.err);
                end
            end
        end
        if (!if_rvalid_o) check("if_err_idle", if_err_o, 1'b0);
        if (!dm_done_o)   check("dm_err_idle", dm_err_o, 1'b0);
    end

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {if_gnt_o, if_rvalid_o, if_err_o, dm_gnt_o, dm_done_o, dm_err_o,
                               ram_read_en_o, ram_write_en_o, ram_read_instruction_o, busy_o}, 80'd0);
        check({name, "_addr"}, ram_addr_o, 80'd0);
        check({name, "_wdata"}, ram_write_data_o, 80'd0);
        check({name, "_rdata"}, dm_rdata_o, 80'd0);
        check({name, "_instr"}, if_instr_o, 80'd0);
    endtask

    task automatic drop_reqs();
        if_req_i   = 1'b0;
        dm_req_i   = 1'b0;
        if_addr_i  = 64'hFFFF_FFFF_FFFF_0001;
        dm_addr_i  = 64'hFFFF_FFFF_FFFF_0002;
        dm_wdata_i = 64'hFFFF_FFFF_FFFF_0003;
        dm_we_i    = 1'b1;
    endtask

    task automatic wait_gnt(output logic got);
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk_i);
            if (if_gnt_o || dm_gnt_o) got = 1'b1;
        end
        if (!got) check("gnt_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_idle();
        logic done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk_i);
            #1;
            if (!busy_o && sb.size() == 0) done = 1'b1;
        end
        if (!done) check("drain_timeout", 1'b0, 1'b1);
    endtask

    typedef struct {
        logic        ifr;
        logic        dmr;
        logic        we;
        logic [63:0] iaddr;
        logic [63:0] daddr;
        logic [63:0] wdata;
        logic        exp_fetch;
    } vec_t;

    task automatic do_access(input vec_t v);
        logic        got;
        logic        we;
        logic [63:0] addr;
        @(posedge clk_i);
        #1;
        if_req_i = v.ifr;  if_addr_i = v.iaddr;
        dm_req_i = v.dmr;  dm_we_i = v.we;  dm_addr_i = v.daddr;  dm_wdata_i = v.wdata;
        wait_gnt(got);
        if (!got) begin
            drop_reqs();
            return;
        end
        we   = ~v.exp_fetch & v.we;
        addr = v.exp_fetch ? v.iaddr : v.daddr;
        check("winner", {if_gnt_o, dm_gnt_o}, {v.exp_fetch, ~v.exp_fetch});
        check("cmd_en", {ram_read_en_o, ram_write_en_o, ram_read_instruction_o}, {~we, we, v.exp_fetch});
        check("cmd_addr", ram_addr_o, addr);
        if (we) check("cmd_wdata", ram_write_data_o, v.wdata);
        push_exp(v.exp_fetch, we, addr);
        drop_reqs();
        @(negedge clk_i);
        check("wait_en", {ram_read_en_o, ram_write_en_o, ram_read_instruction_o, if_gnt_o, dm_gnt_o}, 5'b0);
        check("wait_busy", busy_o, 1'b1);
        wait_idle();
    endtask

    vec_t vecs[9];

    initial begin
        logic got;
        logic exp_f;
        int   last_cyc;
        logic exp_busy[6]   = '{1, 1, 0, 1, 1, 0};
        logic exp_if_gnt[6] = '{0, 0, 0, 1, 0, 0};
        logic exp_dm_gnt[6] = '{1, 0, 0, 0, 0, 0};

        vecs[0] = '{1, 0, 0, 64'h10,   64'h0,   64'h0,        1};
        vecs[1] = '{0, 1, 1, 64'h0,    64'h100, 64'hDEADBEEF, 0};
        vecs[2] = '{0, 1, 0, 64'h0,    64'h100, 64'h0,        0};
        vecs[3] = '{1, 1, 0, 64'h20,   64'h208, 64'h0,        0};
        vecs[4] = '{0, 1, 1, 64'h0,    64'h300, 64'h1234_5678, 0};
        vecs[5] = '{1, 0, 0, ERR_ADDR, 64'h0,   64'h0,        1};
        vecs[6] = '{0, 1, 0, 64'h0,    ERR_ADDR, 64'h0,       0};
        vecs[7] = '{1, 1, 1, 64'h30,   64'h400, 64'hCAFE,     0};
        vecs[8] = '{1, 0, 0, 64'h40,   64'h0,   64'h0,        1};

        rst_n_i = 1'b0;
        drop_reqs();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset");
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check("idle_no_req", {busy_o, ram_read_en_o, ram_write_en_o}, 3'b0);

        foreach (vecs[i]) do_access(vecs[i]);

        // Sustained contention: grant pattern and one grant per 3 cycles.
        @(posedge clk_i);
        #1;
        if_req_i = 1'b1;  if_addr_i = 64'h500;
        dm_req_i = 1'b1;  dm_we_i = 1'b0;  dm_addr_i = 64'h600;
        last_cyc = 0;
        for (int k = 0; k < 6; k++) begin
            wait_gnt(got);
            if (!got) break;
`ifdef RAM_ARB_STARVE_GUARD_EN
            exp_f = (k % 3 == 2);
`else
            exp_f = 1'b0;
`endif
            check("stream_winner", {if_gnt_o, dm_gnt_o}, {exp_f, ~exp_f});
            if (k > 0) check("stream_period", 80'(cyc - last_cyc), 80'd3);
            last_cyc = cyc;
            push_exp(exp_f, 1'b0, exp_f ? 64'h500 : 64'h600);
        end
        drop_reqs();
        wait_idle();

        // Data first, fetch three cycles later once the data request drops.
        @(posedge clk_i);
        #1;
        if_req_i = 1'b1;  if_addr_i = 64'h700;
        dm_req_i = 1'b1;  dm_we_i = 1'b0;  dm_addr_i = 64'h708;
        wait_gnt(got);
        if (got) begin
            for (int k = 0; k < 6; k++) begin
                if (k > 0) @(negedge clk_i);
                check("seq_busy", busy_o, exp_busy[k]);
                check("seq_gnt", {if_gnt_o, dm_gnt_o}, {exp_if_gnt[k], exp_dm_gnt[k]});
                if (if_gnt_o) push_exp(1'b1, 1'b0, 64'h700);
                if (dm_gnt_o) push_exp(1'b0, 1'b0, 64'h708);
                if (k == 0) dm_req_i = 1'b0;
                if (k == 3) if_req_i = 1'b0;
            end
        end
        drop_reqs();
        wait_idle();

        // Reset during WAIT of a data read aborts it with no completion pulse.
        @(posedge clk_i);
        #1;
        dm_req_i = 1'b1;  dm_we_i = 1'b0;  dm_addr_i = 64'h800;
        wait_gnt(got);
        drop_reqs();
        @(negedge clk_i);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        check_all_zero("abort");
        exp_rdata = 64'd0;
        rst_n_i = 1'b1;
        repeat (4) @(negedge clk_i);
        check("abort_busy", busy_o, 1'b0);

        do_access('{0, 1, 0, 64'h0, 64'h810, 64'h0, 0});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
